// File: rtl/instr_decode_stage.sv
// RV32I decode stage: splits fetch words into fields, builds the immediate, classifies and
// legality-checks the opcode, and buffers decoded records in a 2-entry queue toward issue.
module instr_decode_stage #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [2:0]       out_class,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_rd_we,
    output logic             out_rs1_used,
    output logic             out_rs2_used,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_illegal
);

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LOAD = 3'd2,
        CLS_S    = 3'd3,
        CLS_B    = 3'd4,
        CLS_JAL  = 3'd5,
        CLS_UNK  = 3'd7
    } instr_class_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        rd_we;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } dec_rec_t;

    dec_rec_t     dec;
    dec_rec_t     head;
    dec_rec_t     tail;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    instr_class_e cls;
    logic         legal;
    logic         writes_rd;
    logic         uses_rs1;
    logic         uses_rs2;
    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [6:0]   f7;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    always_comb begin
        cls       = CLS_UNK;
        legal     = 1'b0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        dec       = '0;
        dec.pc     = in_pc;
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        dec.funct7 = f7;
        case (opcode)
            7'b0110011: begin
                cls       = CLS_R;
                legal     = (f3 == 3'd0 || f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : (f7 == 7'd0);
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            7'b0010011: begin
                cls       = CLS_I;
                legal     = (f3 == 3'd1) ? (f7 == 7'd0) :
                            (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
                dec.imm   = {{20{in_instr[31]}}, in_instr[31:20]};
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            7'b0000011: begin
                cls       = CLS_LOAD;
                legal     = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
                dec.imm   = {{20{in_instr[31]}}, in_instr[31:20]};
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            7'b0100011: begin
                cls       = CLS_S;
                legal     = (f3 <= 3'd2);
                dec.imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            7'b1100011: begin
                cls       = CLS_B;
                legal     = (f3 != 3'd2 && f3 != 3'd3);
                dec.imm   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            7'b1101111: begin
                cls       = CLS_JAL;
                legal     = 1'b1;
                dec.imm   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            default: begin
                cls   = CLS_UNK;
                legal = 1'b0;
            end
        endcase
        dec.cls      = cls;
        dec.illegal  = !legal;
        dec.rd_we    = writes_rd && legal && (in_instr[11:7] != 5'd0);
        dec.rs1_used = uses_rs1 && legal;
        dec.rs2_used = uses_rs2 && legal;
    end

    assign in_ready  = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Push and pop together only happen at count 1 (count 2 blocks push, count 0 has no pop),
    // so the new record goes straight to the head slot in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            head        <= '0;
            tail        <= '0;
            cnt_total   <= '0;
            cnt_illegal <= '0;
        end else begin
            if (push) begin
                cnt_total <= cnt_total + 1'b1;
                if (dec.illegal) cnt_illegal <= cnt_illegal + 1'b1;
            end
            if (flush) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) head <= dec;
                        else               tail <= dec;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    2'b11: head <= dec;
                    default: ;
                endcase
            end
        end
    end

    assign out_pc       = head.pc;
    assign out_class    = head.cls;
    assign out_rd       = head.rd;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_funct3   = head.funct3;
    assign out_funct7   = head.funct7;
    assign out_imm      = head.imm;
    assign out_rd_we    = head.rd_we;
    assign out_rs1_used = head.rs1_used;
    assign out_rs2_used = head.rs2_used;
    assign out_illegal  = head.illegal;

endmodule
